// File: rtl/duck_pkg.sv
// Shared constants, configuration record and frame helpers for the duck sprite scheduler.
package duck_pkg;

  localparam int NUM_DUCKS       = 4;
  localparam int SPR_W           = 68;
  localparam int SPR_H           = 64;
  localparam int NUM_FRAMES      = 3;
  localparam int FRAME_TICKS     = 8;
  localparam int ADDR_W          = 14;
  localparam int TRANSPARENT_IDX = 0;
  localparam int FRAME_BYTES     = SPR_W * SPR_H;

  localparam int DUCK_W  = $clog2(NUM_DUCKS);
  localparam int FRAME_W = $clog2(NUM_FRAMES);
  localparam int TICK_W  = $clog2(FRAME_TICKS);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } duck_cfg_t;

  localparam duck_cfg_t DUCK_CFG_RST = '{x: 10'd0, y: 10'd0, en: 1'b0};

  // Frame shown by a given duck: ducks are phase-shifted by their index.
  function automatic logic [FRAME_W-1:0] duck_frame(input logic [FRAME_W-1:0] anim, input int idx);
    int sum;
    sum = int'(anim) + idx;
    return FRAME_W'(sum % NUM_FRAMES);
  endfunction

  // ROM base address of an animation frame (frames are stacked back to back).
  function automatic logic [ADDR_W-1:0] frame_base(input logic [FRAME_W-1:0] frame);
    return ADDR_W'(int'(frame) * FRAME_BYTES);
  endfunction

endpackage

// File: rtl/duck_sprite_scheduler_if.sv
// Configuration write bus from the game logic to the sprite scheduler.
interface duck_sprite_scheduler_if
  import duck_pkg::*;
();

  logic              cfg_we;
  logic [DUCK_W-1:0] cfg_idx;
  logic [9:0]        cfg_x;
  logic [9:0]        cfg_y;
  logic              cfg_en;

  modport master (output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en);
  modport slave  (input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_en);

endinterface

// File: rtl/duck_hit_detect.sv
// Per-duck bounding-box test and sprite-local pixel offset.
module duck_hit_detect
  import duck_pkg::*;
(
  input  duck_cfg_t         cfg,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              hit,
  output logic [ADDR_W-1:0] offset
);

  logic [10:0] x_s;
  logic [10:0] y_s;
  logic [10:0] cx_s;
  logic [10:0] cy_s;
  logic [10:0] dx_s;
  logic [10:0] dy_s;

  // 11-bit compare so a sprite near the right/bottom edge never wraps to the left/top.
  always_comb begin
    x_s    = {1'b0, DrawX};
    y_s    = {1'b0, DrawY};
    cx_s   = {1'b0, cfg.x};
    cy_s   = {1'b0, cfg.y};
    dx_s   = x_s - cx_s;
    dy_s   = y_s - cy_s;
    hit    = cfg.en
          && (x_s >= cx_s) && (x_s < (cx_s + 11'(SPR_W)))
          && (y_s >= cy_s) && (y_s < (cy_s + 11'(SPR_H)));
    offset = (ADDR_W'(dy_s) * ADDR_W'(SPR_W)) + ADDR_W'(dx_s);
  end

endmodule

// File: rtl/duck_sprite_scheduler.sv
// Shares one stacked-frame duck ROM among several ducks: double-buffered config,
// global animation counter, priority hit selection and a fixed two-stage pixel pipeline.
module duck_sprite_scheduler
  import duck_pkg::*;
(
  input  logic                   vga_clk,
  input  logic                   reset_n,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   blank,
  duck_sprite_scheduler_if.slave cfg_bus,
  output logic [ADDR_W-1:0]      rom_address,
  input  logic [3:0]             rom_q,
  output logic [3:0]             pix_index,
  output logic [DUCK_W-1:0]      pix_duck,
  output logic                   pix_valid,
  output logic [FRAME_W-1:0]     anim_frame
);

  duck_cfg_t shadow_r      [NUM_DUCKS];
  duck_cfg_t shadow_next_s [NUM_DUCKS];
  duck_cfg_t active_r      [NUM_DUCKS];

  logic                commit_s;
  logic [TICK_W-1:0]   tick_r;
  logic [FRAME_W-1:0]  anim_frame_r;

  logic [NUM_DUCKS-1:0] hit_s;
  logic [ADDR_W-1:0]    offset_s    [NUM_DUCKS];
  logic [ADDR_W-1:0]    duck_addr_s [NUM_DUCKS];

  logic              win_hit_s;
  logic [DUCK_W-1:0] win_idx_s;
  logic [ADDR_W-1:0] win_addr_s;

  logic [ADDR_W-1:0] rom_address_r;
  logic              hit1_r;
  logic [DUCK_W-1:0] duck1_r;
  logic              blank1_r;
  logic [3:0]        pix_index_r;
  logic [DUCK_W-1:0] pix_duck_r;
  logic              pix_valid_r;

  // Config swap happens at the start of vertical blanking.
  assign commit_s = (DrawX == 10'd0) && (DrawY == 10'd480);

  // Shadow contents including this cycle's write, so a write coinciding with commit is kept.
  always_comb begin
    for (int i = 0; i < NUM_DUCKS; i++) begin
      shadow_next_s[i] = shadow_r[i];
    end
    if (cfg_bus.cfg_we) begin
      shadow_next_s[cfg_bus.cfg_idx] = '{x: cfg_bus.cfg_x, y: cfg_bus.cfg_y, en: cfg_bus.cfg_en};
    end else begin
      shadow_next_s[0] = shadow_r[0];
    end
  end

  // Shadow and active config registers; active only changes on commit.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DUCKS; i++) begin
        shadow_r[i] <= DUCK_CFG_RST;
        active_r[i] <= DUCK_CFG_RST;
      end
    end else begin
      for (int i = 0; i < NUM_DUCKS; i++) begin
        shadow_r[i] <= shadow_next_s[i];
        if (commit_s) begin
          active_r[i] <= shadow_next_s[i];
        end
      end
    end
  end

  // Vertical-blank tick counter advancing the global animation frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_r       <= {TICK_W{1'b0}};
      anim_frame_r <= {FRAME_W{1'b0}};
    end else if (commit_s) begin
      if (tick_r == TICK_W'(FRAME_TICKS - 1)) begin
        tick_r <= {TICK_W{1'b0}};
        if (anim_frame_r == FRAME_W'(NUM_FRAMES - 1)) begin
          anim_frame_r <= {FRAME_W{1'b0}};
        end else begin
          anim_frame_r <= anim_frame_r + FRAME_W'(1);
        end
      end else begin
        tick_r <= tick_r + TICK_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_DUCKS; g++) begin : g_duck
    duck_hit_detect u_hit (
      .cfg    (active_r[g]),
      .DrawX  (DrawX),
      .DrawY  (DrawY),
      .hit    (hit_s[g]),
      .offset (offset_s[g])
    );
    assign duck_addr_s[g] = frame_base(duck_frame(anim_frame_r, g)) + offset_s[g];
  end

  // Priority encoder: lowest-index hitting duck owns the pixel.
  always_comb begin
    win_hit_s  = 1'b0;
    win_idx_s  = {DUCK_W{1'b0}};
    win_addr_s = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_DUCKS; i++) begin
      if (hit_s[i] && !win_hit_s) begin
        win_hit_s  = 1'b1;
        win_idx_s  = DUCK_W'(i);
        win_addr_s = duck_addr_s[i];
      end else begin
        win_hit_s  = win_hit_s;
      end
    end
  end

  // Stage 1: ROM address plus the side-band needed to qualify the returned colour.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address_r <= {ADDR_W{1'b0}};
      hit1_r        <= 1'b0;
      duck1_r       <= {DUCK_W{1'b0}};
      blank1_r      <= 1'b0;
    end else begin
      rom_address_r <= win_addr_s;
      hit1_r        <= win_hit_s;
      duck1_r       <= win_idx_s;
      blank1_r      <= blank;
    end
  end

  // Stage 2: tag the ROM colour; a transparent top duck does not reveal ducks below it.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_index_r <= 4'd0;
      pix_duck_r  <= {DUCK_W{1'b0}};
      pix_valid_r <= 1'b0;
    end else begin
      pix_index_r <= hit1_r ? rom_q : 4'd0;
      pix_duck_r  <= duck1_r;
      pix_valid_r <= hit1_r && blank1_r && (rom_q != 4'(TRANSPARENT_IDX));
    end
  end

  assign rom_address = rom_address_r;
  assign pix_index   = pix_index_r;
  assign pix_duck    = pix_duck_r;
  assign pix_valid   = pix_valid_r;
  assign anim_frame  = anim_frame_r;

endmodule

// File: tb/tb_duck_sprite_scheduler.sv
// Directed bench for duck_sprite_scheduler with hand-computed expected values.
module tb_duck_sprite_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [13:0] rom_address;
  logic [3:0]  rom_q;
  logic [3:0]  pix_index;
  logic [1:0]  pix_duck;
  logic        pix_valid;
  logic [1:0]  anim_frame;

  int n_total = 0;
  int n_bad   = 0;

  duck_sprite_scheduler_if cfg_bus ();

  duck_sprite_scheduler dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .cfg_bus     (cfg_bus.slave),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_index   (pix_index),
    .pix_duck    (pix_duck),
    .pix_valid   (pix_valid),
    .anim_frame  (anim_frame)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full clock: inputs set at negedge are captured, outputs observed at the next negedge.
  task automatic step();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input logic en);
    cfg_bus.cfg_we  = 1'b1;
    cfg_bus.cfg_idx = 2'(idx);
    cfg_bus.cfg_x   = 10'(x);
    cfg_bus.cfg_y   = 10'(y);
    cfg_bus.cfg_en  = en;
    step();
    cfg_bus.cfg_we  = 1'b0;
  endtask

  task automatic commit();
    DrawX = 10'd0;
    DrawY = 10'd480;
    blank = 1'b0;
    step();
    DrawX = 10'd1;
    DrawY = 10'd481;
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic b, input int q,
                       input int e_addr, input int e_idx, input int e_duck, input int e_valid);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    step();
    check_val({tag, "_addr"}, 32'(rom_address), 32'(e_addr));
    rom_q = 4'(q);
    step();
    check_val({tag, "_idx"}, 32'(pix_index), 32'(e_idx));
    check_val({tag, "_duck"}, 32'(pix_duck), 32'(e_duck));
    check_val({tag, "_valid"}, 32'(pix_valid), 32'(e_valid));
  endtask

  initial begin
    reset_n         = 1'b1;
    DrawX           = 10'd100;
    DrawY           = 10'd50;
    blank           = 1'b1;
    rom_q           = 4'd0;
    cfg_bus.cfg_we  = 1'b0;
    cfg_bus.cfg_idx = 2'd0;
    cfg_bus.cfg_x   = 10'd0;
    cfg_bus.cfg_y   = 10'd0;
    cfg_bus.cfg_en  = 1'b0;

    // Reset asserted mid-frame at DrawX=100.
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_addr", 32'(rom_address), 32'd0);
    check_val("rst_valid", 32'(pix_valid), 32'd0);
    check_val("rst_anim", 32'(anim_frame), 32'd0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    rom_q   = 4'd5;
    step();
    step();
    step();
    check_val("post_rst_valid", 32'(pix_valid), 32'd0);
    check_val("post_rst_idx", 32'(pix_index), 32'd0);
    check_val("post_rst_anim", 32'(anim_frame), 32'd0);

    // Duck 0 at (100,50): first pixel, last pixel, just past the right edge.
    cfg_write(0, 100, 50, 1'b1);
    probe("pre_commit", 100, 50, 1'b1, 3, 0, 0, 0, 0);
    commit();
    probe("d0_first", 100, 50, 1'b1, 3, 0, 3, 0, 1);
    probe("d0_last", 167, 113, 1'b1, 9, 4351, 9, 0, 1);
    probe("d0_right", 168, 113, 1'b1, 9, 0, 0, 0, 0);

    // Ducks 1 and 2 at anim 0 use frames 1 and 2.
    cfg_write(1, 200, 200, 1'b1);
    cfg_write(2, 400, 100, 1'b1);
    commit();
    probe("d1_base", 200, 200, 1'b1, 7, 4352, 7, 1, 1);
    probe("d2_off", 401, 101, 1'b1, 2, 8773, 2, 2, 1);

    // Duck 0 stacked on duck 1: a transparent top pixel does not fall through.
    cfg_write(0, 200, 200, 1'b1);
    commit();
    probe("ovl_transp", 210, 205, 1'b1, 0, 350, 0, 0, 0);
    probe("ovl_opaque", 210, 205, 1'b1, 5, 350, 5, 0, 1);
    probe("ovl_blank", 210, 205, 1'b0, 5, 350, 5, 0, 0);

    // Latency: the pixel appears on the second edge, not the first.
    probe("lat_miss", 10, 10, 1'b1, 0, 0, 0, 0, 0);
    DrawX = 10'd210;
    DrawY = 10'd205;
    blank = 1'b1;
    rom_q = 4'd5;
    step();
    check_val("lat_early_valid", 32'(pix_valid), 32'd0);
    step();
    check_val("lat_on_time_valid", 32'(pix_valid), 32'd1);
    check_val("lat_on_time_idx", 32'(pix_index), 32'd5);

    // Write coinciding with commit is taken in that commit.
    probe("hz_before", 310, 205, 1'b1, 1, 0, 0, 0, 0);
    DrawX           = 10'd0;
    DrawY           = 10'd480;
    blank           = 1'b0;
    cfg_bus.cfg_we  = 1'b1;
    cfg_bus.cfg_idx = 2'd0;
    cfg_bus.cfg_x   = 10'd300;
    cfg_bus.cfg_y   = 10'd200;
    cfg_bus.cfg_en  = 1'b1;
    step();
    cfg_bus.cfg_we  = 1'b0;
    probe("hz_new", 310, 205, 1'b1, 1, 350, 1, 0, 1);
    probe("hz_uncover", 210, 205, 1'b1, 2, 4702, 2, 1, 1);

    // Write one cycle after commit waits for the following commit.
    DrawX = 10'd0;
    DrawY = 10'd480;
    blank = 1'b0;
    step();
    DrawX = 10'd1;
    DrawY = 10'd481;
    cfg_write(0, 500, 200, 1'b1);
    probe("late_not_yet", 510, 205, 1'b1, 3, 0, 0, 0, 0);
    probe("late_old_pos", 310, 205, 1'b1, 1, 350, 1, 0, 1);
    commit();
    probe("late_applied", 510, 205, 1'b1, 3, 350, 3, 0, 1);
    probe("late_old_gone", 310, 205, 1'b1, 1, 0, 0, 0, 0);

    // Animation: six commits so far; the 8th advances the frame.
    commit();
    check_val("anim_c7", 32'(anim_frame), 32'd0);
    commit();
    check_val("anim_c8", 32'(anim_frame), 32'd1);
    probe("anim1_d0", 510, 205, 1'b1, 3, 4702, 3, 0, 1);
    repeat (8) commit();
    check_val("anim_c16", 32'(anim_frame), 32'd2);
    probe("anim2_d0", 510, 205, 1'b1, 3, 9054, 3, 0, 1);
    probe("anim2_d1", 210, 205, 1'b1, 6, 350, 6, 1, 1);
    repeat (7) commit();
    check_val("anim_c23", 32'(anim_frame), 32'd2);
    commit();
    check_val("anim_c24", 32'(anim_frame), 32'd0);
    probe("anim0_d0", 510, 205, 1'b1, 3, 350, 3, 0, 1);

    // Sprite hanging off the bottom-right corner.
    cfg_write(3, 600, 450, 1'b1);
    commit();
    probe("edge_hit", 639, 479, 1'b1, 4, 2011, 4, 3, 1);
    probe("edge_nowrap", 0, 479, 1'b1, 4, 0, 0, 0, 0);

    // Reset again with a valid pixel in flight; config is wiped.
    probe("edge_hit2", 639, 479, 1'b1, 4, 2011, 4, 3, 1);
    #2 reset_n = 1'b0;
    #1;
    check_val("rst2_addr", 32'(rom_address), 32'd0);
    check_val("rst2_idx", 32'(pix_index), 32'd0);
    check_val("rst2_duck", 32'(pix_duck), 32'd0);
    check_val("rst2_valid", 32'(pix_valid), 32'd0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    probe("rst2_cleared", 639, 479, 1'b1, 4, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/duck_sprite_scheduler.md
Name: duck_sprite_scheduler

Overview:
Shares one duck sprite ROM (all animation frames stacked) among NUM_DUCKS on-screen ducks. For each pixel it selects the highest-priority duck covering DrawX/DrawY and generates the ROM address for that duck's current animation frame. It then returns the ROM colour index, tagged with the owning duck, to the palette/compositor stage. Sits between the VGA controller, game logic (config writes) and the duck ROM + palette.

Parameters:
NUM_DUCKS, 4, number of duck instances; index 0 has highest priority
SPR_W, 68, sprite width in pixels
SPR_H, 64, sprite height in pixels
NUM_FRAMES, 3, animation frames stacked in ROM, frame f at base f*SPR_W*SPR_H
FRAME_TICKS, 8, vertical blanks per animation step
ADDR_W, 14, ROM address width (must hold NUM_FRAMES*SPR_W*SPR_H)
TRANSPARENT_IDX, 0, ROM colour index treated as transparent

Ports:
vga_clk  in  1  pixel clock; sole clock
reset_n  in  1  asynchronous active-low reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  high = active display region
cfg_we  in  1  write strobe for the shadow config of duck cfg_idx
cfg_idx  in  $clog2(NUM_DUCKS)  duck being configured
cfg_x  in  10  sprite left edge
cfg_y  in  10  sprite top edge
cfg_en  in  1  duck visible
rom_address  out  ADDR_W  to ROM (ROM clocked on ~vga_clk)
rom_q  in  4  ROM colour index, valid before the next posedge
pix_index  out  4  colour index for the palette
pix_duck  out  $clog2(NUM_DUCKS)  duck owning the pixel
pix_valid  out  1  opaque duck pixel in the active region
anim_frame  out  $clog2(NUM_FRAMES)  current global animation frame

Behaviour:
- Reset (async assert, sync release): shadow and active config all zero (every duck disabled), tick counter 0, anim_frame 0, all pipeline registers and outputs 0.
- Config double buffering: cfg_we writes {x,y,en} into shadow[cfg_idx] on posedge. Commit pulse = (DrawX==0 && DrawY==480). On commit, active <= shadow. If cfg_we and commit fall in the same cycle, the new write is included in the committed value (write-through).
- Animation: on each commit the tick counter increments. At FRAME_TICKS-1 it wraps to 0 and anim_frame advances mod NUM_FRAMES (2 -> 0).
- Per-duck frame: (anim_frame + duck index) mod NUM_FRAMES, so ducks flap out of phase.
- Hit test (combinational, stage 0): duck i hits when en && x<=DrawX<x+SPR_W && y<=DrawY<y+SPR_H.
  - Compare in 11 bits so x+SPR_W never wraps; sprites may extend off the right/bottom edge.
  - Lowest hitting index wins; no hit means miss.
- Stage 1 (posedge after DrawX): rom_address <= frame*SPR_W*SPR_H + (DrawY-y)*SPR_W + (DrawX-x) for the winner, 0 on miss. Hit flag, winner index and blank are registered alongside.
- Stage 2 (next posedge): pix_index <= rom_q, pix_duck <= stage-1 winner, pix_valid <= hit1 && blank1 && (rom_q != TRANSPARENT_IDX). On miss, pix_index is 0.
- Latency: DrawX/DrawY/blank at edge k -> pix_* at edge k+2. Fixed, with no stalls.
- Overlap: a transparent pixel of a higher-priority duck does not fall through to a lower duck. pix_valid=0 and the background shows.

Decomposition:
- Package duck_pkg: SPR_W, SPR_H, NUM_FRAMES, FRAME_BYTES=SPR_W*SPR_H, and typedef struct duck_cfg_t {logic [9:0] x, y; logic en;}.
- Sub-module duck_hit_detect (one per duck via generate): inputs duck_cfg_t, DrawX, DrawY; outputs hit and local offset (DrawY-y)*SPR_W+(DrawX-x).
- The top level holds the priority encoder, frame/tick counters, shadow/active registers and pipeline.

Test Plan:
- Reset mid-frame with reset_n low at DrawX=100 -> all outputs 0 immediately; after release, pix_valid stays 0 because every duck is disabled.
- Write duck0 x=100 y=50 en=1, then reach commit -> at DrawX=100 DrawY=50, rom_address=0 one cycle later; at DrawX=167 DrawY=113, rom_address=4351; at DrawX=168, miss and rom_address=0.
- Ducks 0 and 1 both at (200,200), ROM returns 0 for duck0's pixel -> pix_duck=0, pix_valid=0 (no fall-through); with rom_q=5 -> pix_index=5, pix_valid=1 exactly 2 cycles after DrawX.
- Animation: step 8 commits -> anim_frame 0->1; step 24 -> back to 0. Duck1 at anim_frame 0 addresses base 4352, duck2 base 8704.
- Config hazard: cfg_we (duck0 x=300) asserted in the same cycle as commit -> new position takes effect next frame. A write one cycle after commit does not appear until the following commit.
- Off-edge: duck at x=600 y=450, DrawX=639 DrawY=479 -> hit, offset 29*68+39=2011; no wrap to the left side at DrawX=0.
